// File: rtl/io_device_endpoint_if.sv
// Bundle of all processor-side and peripheral-side signals for one device slot.
// The master modport is the processor plus peripheral environment; the slave
// modport is the endpoint itself.
interface io_device_endpoint_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 3
);
  logic [WIDTH-1:0] dev_out_word;
  logic             enter_out;
  logic             done_out;
  logic [WIDTH-1:0] dev_in_word;
  logic             enter_in;
  logic             in_ack;
  logic [WIDTH-1:0] sink_data;
  logic             sink_valid;
  logic             sink_ready;
  logic [WIDTH-1:0] src_data;
  logic             src_valid;
  logic             src_ready;
  logic [CW-1:0]    fifo_count;

  modport master (
    output dev_out_word, enter_out, in_ack, sink_ready, src_data, src_valid,
    input  done_out, dev_in_word, enter_in, sink_data, sink_valid, src_ready,
           fifo_count
  );

  modport slave (
    input  dev_out_word, enter_out, in_ack, sink_ready, src_data, src_valid,
    output done_out, dev_in_word, enter_in, sink_data, sink_valid, src_ready,
           fifo_count
  );
endinterface

// File: rtl/io_device_endpoint.sv
// Device-side responder for one processor I/O slot. Words written by the
// processor are acknowledged and buffered in a small FIFO that drains to a
// peripheral sink; words from a peripheral source are captured and offered to
// the processor with a four-phase enter_in/in_ack handshake.
module io_device_endpoint #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic                 clk,
  input logic                 reset,
  io_device_endpoint_if.slave bus
);
  localparam int            AW         = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {O_IDLE, O_ACK} oState_t;
  typedef enum logic [1:0] {I_IDLE, I_OFFER, I_RELEASE} iState_t;

  oState_t          oState_q, oState_d;
  iState_t          iState_q, iState_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] devIn_q, devIn_d;
  logic             push;
  logic             pop;

  // Output handshake: accept one word per enter_out high phase, only when the
  // FIFO has room as seen before this edge, then hold done_out until release.
  always_comb begin
    oState_d = oState_q;
    push     = 1'b0;
    case (oState_q)
      O_IDLE: begin
        if (bus.enter_out && (count_q != FULL_COUNT)) begin
          push     = 1'b1;
          oState_d = O_ACK;
        end
      end
      O_ACK: begin
        if (!bus.enter_out) begin
          oState_d = O_IDLE;
        end
      end
      default: oState_d = O_IDLE;
    endcase
  end

  // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth and the
  // count only moves when exactly one of push/pop happens.
  always_comb begin
    pop     = (count_q != '0) && bus.sink_ready;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Input handshake: capture a source word only when idle, offer it until the
  // processor acks, then wait for the ack to drop before accepting more.
  always_comb begin
    iState_d = iState_q;
    devIn_d  = devIn_q;
    case (iState_q)
      I_IDLE: begin
        if (bus.src_valid) begin
          devIn_d  = bus.src_data;
          iState_d = I_OFFER;
        end
      end
      I_OFFER: begin
        if (bus.in_ack) begin
          iState_d = I_RELEASE;
        end
      end
      I_RELEASE: begin
        if (!bus.in_ack) begin
          iState_d = I_IDLE;
        end
      end
      default: iState_d = I_IDLE;
    endcase
  end

  // State, pointer and captured-word registers; reset abandons everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      oState_q <= O_IDLE;
      iState_q <= I_IDLE;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      devIn_q  <= '0;
    end else begin
      oState_q <= oState_d;
      iState_q <= iState_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      devIn_q  <= devIn_d;
    end
  end

  // FIFO storage needs no reset since the count decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wrPtr_q] <= bus.dev_out_word;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the first
  // reset edge has cleared the state registers.
  assign bus.done_out    = (oState_q == O_ACK) && !reset;
  assign bus.enter_in    = (iState_q == I_OFFER) && !reset;
  assign bus.dev_in_word = reset ? '0 : devIn_q;
  assign bus.src_ready   = (iState_q == I_IDLE) && !reset;
  assign bus.fifo_count  = reset ? '0 : count_q;
  assign bus.sink_valid  = (count_q != '0) && !reset;
  assign bus.sink_data   = mem_q[rdPtr_q];

endmodule

// File: tb/tb_io_device_endpoint.sv
// Bench for io_device_endpoint: directed handshake scenarios followed by a
// randomized run, all checked against a queue-based behavioural model.
module tb_io_device_endpoint;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;

  // Behavioural model: the FIFO is a plain queue, the output side remembers
  // whether this enter_out phase already delivered its word, the input side
  // remembers whether a word is outstanding and whether the ack was seen.
  logic [WIDTH-1:0] modelQ[$];
  bit               pushedThisPhase;
  bit               inBusy;
  bit               inAcked;
  logic [WIDTH-1:0] devExp;

  io_device_endpoint_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  io_device_endpoint #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic eo, input logic [WIDTH-1:0] word,
                               input logic ack, input logic sr,
                               input logic sv, input logic [WIDTH-1:0] sd);
    bus.enter_out    = eo;
    bus.dev_out_word = word;
    bus.in_ack       = ack;
    bus.sink_ready   = sr;
    bus.src_valid    = sv;
    bus.src_data     = sd;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelEdge();
    bit doPush;
    bit doPop;
    if (reset) begin
      modelQ.delete();
      pushedThisPhase = 1'b0;
      inBusy          = 1'b0;
      inAcked         = 1'b0;
      devExp          = '0;
    end else begin
      doPush = bus.enter_out && !pushedThisPhase && (modelQ.size() < DEPTH);
      doPop  = (modelQ.size() != 0) && bus.sink_ready;
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(bus.dev_out_word);
      if (!bus.enter_out) pushedThisPhase = 1'b0;
      else if (doPush) pushedThisPhase = 1'b1;
      if (!inBusy) begin
        if (bus.src_valid) begin
          devExp  = bus.src_data;
          inBusy  = 1'b1;
          inAcked = 1'b0;
        end
      end else if (!inAcked) begin
        if (bus.in_ack) inAcked = 1'b1;
      end else if (!bus.in_ack) begin
        inBusy = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("done_out", 32'(bus.done_out), 32'(pushedThisPhase));
    checkValue("enter_in", 32'(bus.enter_in), 32'(inBusy && !inAcked));
    checkValue("dev_in_word", bus.dev_in_word, devExp);
    checkValue("fifo_count", 32'(bus.fifo_count), 32'(modelQ.size()));
    checkValue("sink_valid", 32'(bus.sink_valid), 32'(modelQ.size() != 0));
    checkValue("src_ready", 32'(bus.src_ready), 32'(!inBusy && !reset));
    if (modelQ.size() != 0) begin
      checkValue("sink_data", bus.sink_data, modelQ[0]);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  // Directed scenarios, then a randomized run with a mid-run reset.
  initial begin
    checkCount      = 0;
    failCount       = 0;
    pushedThisPhase = 1'b0;
    inBusy          = 1'b0;
    inAcked         = 1'b0;
    devExp          = '0;

    // Reset held with requests pending on both sides.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h0000_0077);
    step(2);
    checkValue("reset_done", 32'(bus.done_out), 32'd0);
    checkValue("reset_count", 32'(bus.fifo_count), 32'd0);
    reset = 1'b0;
    step(1);
    checkValue("post_reset_done", 32'(bus.done_out), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1);
    bus.in_ack = 1'b1;
    step(1);
    bus.in_ack = 1'b0;
    step(1);
    bus.sink_ready = 1'b1;
    step(1);
    bus.sink_ready = 1'b0;

    // Single write held for five cycles yields exactly one push.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    step(5);
    checkValue("single_count", 32'(bus.fifo_count), 32'd1);
    checkValue("single_data", bus.sink_data, 32'hDEAD_BEEF);
    bus.enter_out = 1'b0;
    step(1);
    bus.sink_ready = 1'b1;
    step(1);
    bus.sink_ready = 1'b0;

    // Fill the FIFO, then stall a fifth write.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0, 32'h0);
      step(1);
      bus.enter_out = 1'b0;
      step(1);
    end
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1);
    checkValue("fifth_stall_done", 32'(bus.done_out), 32'd0);
    checkValue("fifth_stall_count", 32'(bus.fifo_count), 32'd4);
    checkValue("drain_order_1", bus.sink_data, 32'h1);
    bus.sink_ready = 1'b1;
    step(1);
    checkValue("full_pop_count", 32'(bus.fifo_count), 32'd3);
    bus.sink_ready = 1'b0;
    step(1);
    checkValue("refill_count", 32'(bus.fifo_count), 32'd4);
    checkValue("refill_done", 32'(bus.done_out), 32'd1);
    bus.enter_out = 1'b0;
    step(1);
    bus.sink_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      checkValue("drain_order", bus.sink_data, 32'(i));
      step(1);
    end
    bus.sink_ready = 1'b0;

    // Input capture, ignored second word, four-phase release.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD);
    step(1);
    checkValue("capture_word", bus.dev_in_word, 32'h0000_ABCD);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_1234);
    step(1);
    checkValue("ignored_word", bus.dev_in_word, 32'h0000_ABCD);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1);
    checkValue("ack_drop_enter", 32'(bus.enter_in), 32'd0);
    bus.in_ack = 1'b0;
    step(1);
    checkValue("release_ready", 32'(bus.src_ready), 32'd1);

    // Concurrent output write and input capture.
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h66);
    step(1);
    checkValue("concurrent_done", 32'(bus.done_out), 32'd1);
    checkValue("concurrent_enter", 32'(bus.enter_in), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1);
    bus.in_ack = 1'b0;
    step(2);

    // Randomized run: processor and peripherals follow their protocols.
    for (int c = 0; c < 500; c++) begin
      reset = (c >= 250 && c < 253);
      if (!bus.enter_out) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.enter_out    = 1'b1;
          bus.dev_out_word = $urandom();
        end
      end else if (pushedThisPhase && $urandom_range(0, 1) == 0) begin
        bus.enter_out = 1'b0;
      end
      if (inBusy && !inAcked) begin
        if ($urandom_range(0, 1) == 0) bus.in_ack = 1'b1;
      end else if (!inBusy || $urandom_range(0, 1) == 0) begin
        bus.in_ack = 1'b0;
      end
      bus.sink_ready = ($urandom_range(0, 2) == 0);
      bus.src_valid  = ($urandom_range(0, 1) == 0);
      bus.src_data   = $urandom();
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/io_device_endpoint.md
Name: io_device_endpoint

Overview:
- Device-side responder for one channel of the processor I/O port: the far end of the enter_out/done_out (output) and enter_in (input) handshakes.
- Accepts words the processor writes to the device and buffers them in a small FIFO, which drains to a peripheral sink (display, disk, UART shim).
- Captures words from a peripheral source and offers them to the processor on dev_in with enter_in.
- One instance per device slot; the top level wires slot i to bits [32i+31:32i] of dev_out/dev_in and to bit i of enter_out/done_out/enter_in.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 4, output FIFO entries (power of two, >= 2).
- CW, 3, count width; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- dev_out_word  in  WIDTH  processor output data for this slot.
- enter_out  in  1  processor output request; held high with data stable until done_out seen.
- done_out  out  1  output acknowledge to processor.
- dev_in_word  out  WIDTH  data offered to processor.
- enter_in  out  1  input word available to processor.
- in_ack  in  1  processor has consumed dev_in_word (four-phase).
- sink_data  out  WIDTH  FIFO head to peripheral.
- sink_valid  out  1  FIFO non-empty.
- sink_ready  in  1  peripheral accepts head this cycle.
- src_data  in  WIDTH  peripheral input word.
- src_valid  in  1  peripheral word present.
- src_ready  out  1  endpoint can capture src_data this cycle.
- fifo_count  out  CW  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: both FSMs return to idle; FIFO pointers and count are 0; done_out=0, enter_in=0, dev_in_word=0, sink_valid=0, src_ready=0 during reset.
- Reset mid-transfer abandons any buffered or offered word. The processor side must re-handshake.
- Output FSM states: O_IDLE and O_ACK.
  - In O_IDLE, with enter_out=1 and fifo_count<DEPTH: push dev_out_word, go to O_ACK, done_out=1 from the next cycle.
  - In O_IDLE with the FIFO full: stall, done_out stays 0, no push.
  - In O_ACK: done_out held at 1. When enter_out=0, go to O_IDLE and done_out=0 the next cycle.
  - Exactly one push per enter_out high phase; latency from enter_out rise to done_out rise is 1 cycle when not full.
- FIFO:
  - sink_valid = (fifo_count != 0); sink_data = head entry (registered storage, combinational read).
  - Pop occurs when sink_valid && sink_ready.
  - Push eligibility uses the pre-edge count, so a push is blocked when full even if a pop happens in the same cycle.
  - Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Input FSM states: I_IDLE, I_OFFER, I_RELEASE.
  - src_ready = 1 only in I_IDLE.
  - In I_IDLE with src_valid=1: register src_data into dev_in_word, go to I_OFFER.
  - In I_OFFER: enter_in=1. When in_ack=1, go to I_RELEASE.
  - In I_RELEASE: enter_in=0. When in_ack=0, go to I_IDLE.
  - dev_in_word holds its value until the next capture.
  - src_valid outside I_IDLE is ignored; no data is captured.
- Output and input paths are independent and may be active in the same cycle.

Test Plan:
- Reset held 2 cycles with enter_out=1 and src_valid=1 -> done_out=0, enter_in=0, fifo_count=0, sink_valid=0 throughout; on release, done_out=1 one cycle after the first idle-state edge.
- Single write of 0xDEADBEEF with sink_ready=0 -> done_out rises 1 cycle later; fifo_count=1; sink_data=0xDEADBEEF; enter_out held 5 cycles gives exactly one push.
- Four writes 0x1..0x4 then a fifth 0x5 with sink_ready=0 -> fifth write sees done_out=0 and fifo_count=4.
  - Raise sink_ready for 1 cycle -> 0x1 pops; 0x5 pushed the following cycle.
  - Drain order is 1,2,3,4,5.
- Full FIFO with enter_out=1 and sink_ready=1 in the same cycle -> no push that cycle, count goes 4->3, push next cycle, count back to 4.
- src_data=0x0000ABCD, src_valid pulse -> enter_in=1 next cycle with dev_in_word=0xABCD.
  - A second src_valid=0x1234 while offering is ignored.
  - in_ack high -> enter_in drops; in_ack low -> src_ready=1.
- Concurrent output write 0x55 and input capture 0x66 in the same cycle -> both handshakes complete, each at its normal 1-cycle latency.
